// File: rtl/kronos_dbus_pkg.sv
// Shared types and constants for the kronos data-bus controller:
// FSM states, address regions, MMIO register offsets and a byte-lane merge helper.
package kronos_dbus_pkg;

    // Bus handshake state: a request is taken in IDLE and acknowledged in ACK.
    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    // Target selected by data_addr[31:28].
    typedef enum logic [1:0] {
        REGION_NONE = 2'd0,
        REGION_RAM  = 2'd1,
        REGION_MMIO = 2'd2
    } region_t;

    localparam logic [3:0] RAM_BASE_DEFAULT  = 4'h1;
    localparam logic [3:0] MMIO_BASE_DEFAULT = 4'h2;

    // MMIO register offsets within the page (data_addr[7:0]).
    localparam logic [7:0] LED_OFS         = 8'h00;
    localparam logic [7:0] HEX_OFS         = 8'h04;
    localparam logic [7:0] SW_OFS          = 8'h08;
    localparam logic [7:0] KEY_OFS         = 8'h0C;
    localparam logic [7:0] MTIME_LO_OFS    = 8'h10;
    localparam logic [7:0] MTIME_HI_OFS    = 8'h14;
    localparam logic [7:0] MTIMECMP_LO_OFS = 8'h18;
    localparam logic [7:0] MTIMECMP_HI_OFS = 8'h1C;
    localparam logic [7:0] MSIP_OFS        = 8'h20;

    // Compare value after reset: no timer interrupt until software programs it.
    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    // Replace only the byte lanes whose mask bit is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  mask);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dbus_ram.sv
// Single-port synchronous data RAM with per-byte write enables and a registered
// read port, written in the shape FPGA tools map onto block RAM (M10K).
module dbus_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data
);

    localparam int DEPTH = 2 ** AW;

    logic [31:0] mem [DEPTH];

    // Byte-masked write and read-before-write registered read on every enabled cycle.
    // NOTE: the array has no reset on purpose; a reset term would stop block-RAM
    // inference, and non-blocking assignments keep the old word visible to the read.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
            rd_data <= mem[addr];
        end
    end

endmodule

// File: rtl/kronos_dbus_ctrl.sv
// Data-bus slave for the kronos core: decodes each load/store into the data RAM
// or the MMIO page (LEDs, HEX, switches, keys, machine timer, software interrupt),
// answers every request with a one-cycle data_ack and drives the core's
// timer/software interrupt lines.
module kronos_dbus_ctrl
    import kronos_dbus_pkg::*;
#(
    parameter int         RAM_AW    = 10,
    parameter logic [3:0] RAM_BASE  = RAM_BASE_DEFAULT,
    parameter logic [3:0] MMIO_BASE = MMIO_BASE_DEFAULT,
    parameter int         TIMER_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr_data,
    input  logic [3:0]  data_mask,
    input  logic        data_wr_en,
    input  logic        data_req,
    output logic        data_ack,
    output logic [31:0] data_rd_data,
    input  logic [9:0]  sw_in,
    input  logic [3:0]  key_in,
    output logic [7:0]  led_out,
    output logic [15:0] hex_out,
    output logic        timer_interrupt,
    output logic        software_interrupt
);

    localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

    state_t        state;
    region_t       region;
    logic          take;
    logic          mmio_wr;
    logic [7:0]    ofs;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [31:0]   ram_rd_data;
    logic          sel_ram_q;
    logic [31:0]   rd_q;
    logic [31:0]   mmio_rd_data;
    logic [31:0]   mmio_merged;

    logic [7:0]    led_q;
    logic [15:0]   hex_q;
    logic          msip_q;
    logic [63:0]   mtime;
    logic [63:0]   mtimecmp;
    logic [PW-1:0] presc;
    logic          tick;
    logic          timer_irq_q;

    logic [9:0]    sw_s1, sw_s2;
    logic [3:0]    key_s1, key_s2;

    // Only the upper nibble, the page offset and the RAM word index are decoded.
    logic          unused_addr;
    assign unused_addr = ^data_addr;

    assign ofs  = data_addr[7:0];
    assign take = (state == IDLE) && data_req;

    // Region decode from the top address nibble.
    // NOTE: region gets a default before the if-chain so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        region = REGION_NONE;
        if (data_addr[31:28] == RAM_BASE) begin
            region = REGION_RAM;
        end else if (data_addr[31:28] == MMIO_BASE) begin
            region = REGION_MMIO;
        end
    end

    assign ram_en  = take && (region == REGION_RAM);
    assign ram_we  = (ram_en && data_wr_en) ? data_mask : 4'b0000;
    assign mmio_wr = take && data_wr_en && (region == REGION_MMIO);

    dbus_ram #(
        .AW (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .en      (ram_en),
        .we      (ram_we),
        .addr    (data_addr[RAM_AW+1:2]),
        .wr_data (data_wr_data),
        .rd_data (ram_rd_data)
    );

    // MMIO read mux; unmapped offsets and unused bits read as zero.
    always_comb begin
        mmio_rd_data = 32'h0;
        case (ofs)
            LED_OFS:         mmio_rd_data = {24'h0, led_q};
            HEX_OFS:         mmio_rd_data = {16'h0, hex_q};
            SW_OFS:          mmio_rd_data = {22'h0, sw_s2};
            KEY_OFS:         mmio_rd_data = {28'h0, ~key_s2};
            MTIME_LO_OFS:    mmio_rd_data = mtime[31:0];
            MTIME_HI_OFS:    mmio_rd_data = mtime[63:32];
            MTIMECMP_LO_OFS: mmio_rd_data = mtimecmp[31:0];
            MTIMECMP_HI_OFS: mmio_rd_data = mtimecmp[63:32];
            MSIP_OFS:        mmio_rd_data = {31'h0, msip_q};
            default:         mmio_rd_data = 32'h0;
        endcase
    end

    // Current register value with the enabled store bytes patched in.
    assign mmio_merged = byte_merge(mmio_rd_data, data_wr_data, data_mask);

    // Handshake FSM: take the request in IDLE, acknowledge for exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            data_ack  <= 1'b0;
            sel_ram_q <= 1'b0;
            rd_q      <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_req) begin
                        state     <= ACK;
                        data_ack  <= 1'b1;
                        sel_ram_q <= (region == REGION_RAM) && !data_wr_en;
                        rd_q      <= (region == REGION_MMIO && !data_wr_en) ? mmio_rd_data : 32'h0;
                    end
                end
                ACK: begin
                    state     <= IDLE;
                    data_ack  <= 1'b0;
                    sel_ram_q <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    data_ack  <= 1'b0;
                    sel_ram_q <= 1'b0;
                end
            endcase
        end
    end

    // RAM data comes straight from the RAM output register during ACK.
    assign data_rd_data = sel_ram_q ? ram_rd_data : rd_q;

    // Software-visible LED, HEX, msip and mtimecmp registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q    <= 8'h0;
            hex_q    <= 16'h0;
            msip_q   <= 1'b0;
            mtimecmp <= MTIMECMP_RESET;
        end else if (mmio_wr) begin
            case (ofs)
                LED_OFS:         led_q           <= mmio_merged[7:0];
                HEX_OFS:         hex_q           <= mmio_merged[15:0];
                MTIMECMP_LO_OFS: mtimecmp[31:0]  <= mmio_merged;
                MTIMECMP_HI_OFS: mtimecmp[63:32] <= mmio_merged;
                MSIP_OFS:        msip_q          <= mmio_merged[0];
                default:         ;
            endcase
        end
    end

    assign tick = (presc == PW'(TIMER_DIV - 1));

    // Prescaled 64-bit mtime; a software write to either half pre-empts that cycle's increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            mtime <= 64'h0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (mmio_wr && ofs == MTIME_LO_OFS) begin
                mtime[31:0] <= mmio_merged;
            end else if (mmio_wr && ofs == MTIME_HI_OFS) begin
                mtime[63:32] <= mmio_merged;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
        end
    end

    // Registered unsigned compare for the timer interrupt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_irq_q <= 1'b0;
        end else begin
            timer_irq_q <= (mtime >= mtimecmp);
        end
    end

    // Two-flop synchronisers for the asynchronous board inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1  <= 10'h0;
            sw_s2  <= 10'h0;
            key_s1 <= 4'h0;
            key_s2 <= 4'h0;
        end else begin
            sw_s1  <= sw_in;
            sw_s2  <= sw_s1;
            key_s1 <= key_in;
            key_s2 <= key_s1;
        end
    end

    assign led_out            = led_q;
    assign hex_out            = hex_q;
    assign timer_interrupt    = timer_irq_q;
    assign software_interrupt = msip_q;

endmodule

// File: tb/tb_kronos_dbus_ctrl.sv
// Self-checking bench for kronos_dbus_ctrl: directed scenarios followed by a
// randomized mix of RAM/MMIO/unmapped accesses checked against a small model.
module tb_kronos_dbus_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wr_data = '0;
    logic [3:0]  data_mask = '0;
    logic        data_wr_en = 1'b0;
    logic        data_req = 1'b0;
    logic        data_ack;
    logic [31:0] data_rd_data;
    logic [9:0]  sw_in = '0;
    logic [3:0]  key_in = 4'hF;
    logic [7:0]  led_out;
    logic [15:0] hex_out;
    logic        timer_interrupt;
    logic        software_interrupt;

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;
    logic si_at_ack;

    kronos_dbus_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .data_addr          (data_addr),
        .data_wr_data       (data_wr_data),
        .data_mask          (data_mask),
        .data_wr_en         (data_wr_en),
        .data_req           (data_req),
        .data_ack           (data_ack),
        .data_rd_data       (data_rd_data),
        .sw_in              (sw_in),
        .key_in             (key_in),
        .led_out            (led_out),
        .hex_out            (hex_out),
        .timer_interrupt    (timer_interrupt),
        .software_interrupt (software_interrupt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) if (mask[i]) r[8*i +: 8] = new_val[8*i +: 8];
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One complete bus access; ccyc is the cycle count just after the commit edge.
    task automatic bus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, output logic [31:0] rdata, output int unsigned ccyc);
        int n;
        @(negedge clk);
        data_req = 1'b1; data_wr_en = wr; data_addr = addr; data_wr_data = wdata; data_mask = mask;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!data_ack && n < 8);
        ccyc      = cyc;
        si_at_ack = software_interrupt;
        check("ack_latency", n, 1);
        rdata = data_rd_data;
        @(negedge clk);
        data_req = 1'b0; data_wr_en = 1'b0;
        @(posedge clk); #1;
        check("ack_one_cycle", data_ack, 0);
    endtask

    logic [31:0] rd;
    int unsigned c, cm, c1, c2, r_cyc;
    logic [31:0] ram_m [16];
    logic [7:0]  led_m;
    logic [15:0] hex_m;
    logic        msip_m;
    logic [63:0] mbase;

    initial begin
        // Reset state
        #12;
        check("rst_ack", data_ack, 0);
        check("rst_rd", data_rd_data, 0);
        check("rst_led", led_out, 0);
        check("rst_hex", hex_out, 0);
        check("rst_tirq", timer_interrupt, 0);
        check("rst_sirq", software_interrupt, 0);
        @(negedge clk); rst = 1'b0;
        idle(2);

        // RAM full-word store then load
        bus(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, rd, c);
        bus(1'b0, 32'h1000_0010, 32'h0, 4'hF, rd, c);
        check("ram_word", rd, 32'hDEAD_BEEF);
        // Single-byte store
        bus(1'b1, 32'h1000_0010, 32'h00AA_0000, 4'b0100, rd, c);
        bus(1'b0, 32'h1000_0010, 32'h0, 4'hF, rd, c);
        check("ram_byte", rd, 32'hDEAA_BEEF);

        // LED store, SW load
        bus(1'b1, 32'h2000_0000, 32'h0000_01A5, 4'hF, rd, c);
        check("led_store", led_out, 8'hA5);
        sw_in = 10'h2F3;
        idle(3);
        bus(1'b0, 32'h2000_0008, 32'h0, 4'hF, rd, c);
        check("sw_load", rd, 32'h0000_02F3);

        // Unmapped load, msip store
        bus(1'b0, 32'h3000_0000, 32'h0, 4'hF, rd, c);
        check("unmapped_rd", rd, 0);
        bus(1'b1, 32'h2000_0020, 32'h1, 4'hF, rd, c);
        check("msip_next_cycle", si_at_ack, 1);
        bus(1'b1, 32'h2000_0020, 32'h0, 4'hF, rd, c);
        check("msip_clear", software_interrupt, 0);

        // Back-to-back: req held high gives an ack every other cycle
        @(negedge clk);
        data_req = 1'b1; data_wr_en = 1'b0; data_addr = 32'h1000_0010;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("b2b_ack", data_ack, (i % 2 == 0) ? 1 : 0);
            if (i % 2 == 0) check("b2b_rd", data_rd_data, 32'hDEAA_BEEF);
        end
        @(negedge clk); data_req = 1'b0;
        idle(1);

        // Timer interrupt: mtimecmp = 20, mtime = 0
        bus(1'b1, 32'h2000_001C, 32'h0, 4'hF, rd, c);
        bus(1'b1, 32'h2000_0010, 32'h0, 4'hF, rd, cm);
        bus(1'b1, 32'h2000_0018, 32'd20, 4'hF, rd, c);
        check("tirq_low_before", timer_interrupt, 0);
        while (!timer_interrupt && cyc < cm + 100) begin
            @(posedge clk); #1;
        end
        check("tirq_rise_cycle", cyc - cm, 21);
        bus(1'b0, 32'h2000_0010, 32'h0, 4'hF, rd, c);
        check("mtime_lo_rd", rd, c - 1 - cm);
        bus(1'b1, 32'h2000_0018, 32'hFFFF_FFFF, 4'hF, rd, c);
        check("tirq_clear", timer_interrupt, 0);

        // mtime half writes and 64-bit wrap
        bus(1'b1, 32'h2000_001C, 32'hFFFF_FFFF, 4'hF, rd, c);
        bus(1'b1, 32'h2000_0010, 32'hFFFF_FFF0, 4'hF, rd, c1);
        bus(1'b1, 32'h2000_0014, 32'hFFFF_FFFF, 4'hF, rd, c2);
        mbase = {32'hFFFF_FFFF, 32'hFFFF_FFF0 + 32'(c2 - 1 - c1)};
        bus(1'b0, 32'h2000_0010, 32'h0, 4'hF, rd, c);
        check("mtime_lo_after_hi_wr", rd, 32'(mbase + 64'(c - 1 - c2)));
        idle(20);
        bus(1'b0, 32'h2000_0014, 32'h0, 4'hF, rd, c);
        mbase = mbase + 64'(c - 1 - c2);
        check("mtime_wrap_hi", rd, mbase[63:32]);
        check("mtime_wrapped", rd, 0);
        bus(1'b0, 32'h2000_0018, 32'h0, 4'hF, rd, c);
        check("mtimecmp_lo_rd", rd, 32'hFFFF_FFFF);

        // Randomized mix against the model
        led_m = 8'hA5; hex_m = 16'h0; msip_m = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ram_m[i] = $urandom;
            bus(1'b1, 32'h1000_0000 | 32'(i << 2), ram_m[i], 4'hF, rd, c);
        end
        for (int i = 0; i < 80; i++) begin
            int sel, idx;
            logic wr;
            logic [31:0] d;
            logic [3:0] m;
            logic [3:0] nib;
            sel = $urandom_range(0, 11);
            wr  = 1'($urandom_range(0, 1));
            d   = $urandom;
            m   = 4'($urandom_range(0, 15));
            case (sel)
                0, 1, 2, 3, 4, 5: begin
                    idx = $urandom_range(0, 15);
                    bus(wr, 32'h1000_0000 | 32'(idx << 2) | 32'($urandom_range(0, 3)), d, m, rd, c);
                    if (wr) ram_m[idx] = merge(ram_m[idx], d, m);
                    else check("rnd_ram", rd, ram_m[idx]);
                end
                6: begin
                    bus(wr, 32'h2000_0000, d, m, rd, c);
                    if (wr) begin
                        if (m[0]) led_m = d[7:0];
                        check("rnd_led", led_out, led_m);
                    end else check("rnd_led_rd", rd, {24'h0, led_m});
                end
                7: begin
                    bus(wr, 32'h2000_0004, d, m, rd, c);
                    if (wr) begin
                        hex_m = 16'(merge({16'h0, hex_m}, d, m));
                        check("rnd_hex", hex_out, hex_m);
                    end else check("rnd_hex_rd", rd, {16'h0, hex_m});
                end
                8: begin
                    bus(wr, 32'h2000_0020, d, m, rd, c);
                    if (wr) begin
                        if (m[0]) msip_m = d[0];
                        check("rnd_msip", software_interrupt, msip_m);
                    end else check("rnd_msip_rd", rd, {31'h0, msip_m});
                end
                9: begin
                    idx = $urandom_range(3, 16);
                    nib = (idx == 16) ? 4'h0 : 4'(idx);
                    if ($urandom_range(0, 1) == 1)
                        bus(wr, 32'h2000_0024 + 32'($urandom_range(0, 50) * 4), d, m, rd, c);
                    else
                        bus(wr, {nib, 28'(d)}, d, m, rd, c);
                    if (!wr) check("rnd_unmapped_rd", rd, 0);
                    check("rnd_unmapped_led", led_out, led_m);
                    check("rnd_unmapped_hex", hex_out, hex_m);
                end
                10: begin
                    sw_in = 10'($urandom);
                    idle(3);
                    bus(wr, 32'h2000_0008, d, m, rd, c);
                    if (!wr) check("rnd_sw", rd, {22'h0, sw_in});
                end
                default: begin
                    key_in = 4'($urandom);
                    idle(3);
                    bus(1'b0, 32'h2000_000C, d, m, rd, c);
                    check("rnd_key", rd, {28'h0, ~key_in});
                end
            endcase
        end
        check("rnd_sirq_final", software_interrupt, msip_m);

        // Reset asserted during ACK with data_req still high
        bus(1'b1, 32'h2000_0000, 32'h5A, 4'hF, rd, c);
        @(negedge clk);
        data_req = 1'b1; data_wr_en = 1'b0; data_addr = 32'h1000_0008;
        @(posedge clk); #1;
        check("pre_rst_ack", data_ack, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_ack", data_ack, 0);
        check("rst_mid_led", led_out, 0);
        check("rst_mid_hex", hex_out, 0);
        check("rst_mid_sirq", software_interrupt, 0);
        idle(2);
        check("rst_hold_ack", data_ack, 0);
        @(negedge clk); rst = 1'b0; data_req = 1'b0;
        @(posedge clk); #1;
        r_cyc = cyc;
        check("post_rst_idle", data_ack, 0);
        bus(1'b0, 32'h2000_0010, 32'h0, 4'hF, rd, c);
        check("post_rst_mtime_lo", rd, c - r_cyc);
        bus(1'b0, 32'h2000_0014, 32'h0, 4'hF, rd, c);
        check("post_rst_mtime_hi", rd, 0);
        bus(1'b0, 32'h1000_0008, 32'h0, 4'hF, rd, c);
        check("post_rst_ram", rd, ram_m[2]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
